moravec_score_unit: RTL and testbench

MORAVEC_SCORE_UNIT -- requirements
Module: moravec_score_unit

---
 rtl/moravec_score_unit.sv | 151 +++++++++++++++
 tb/tb_moravec_score_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moravec_score_unit.sv
// Moravec corner score: per-direction SSD accumulation, min search, result hold.
// Optional MORAVEC_THRESH_EN builds the corner-threshold comparator.
module moravec_score_unit #(
  parameter int PIX_W = 8,
  parameter int NDIR  = 4,
  parameter int WIN   = 9,
  localparam int SSD_W = 2*PIX_W + $clog2(WIN),
  localparam int DIR_W = $clog2(NDIR)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIX_W-1:0]       in_center,
  input  logic [NDIR*PIX_W-1:0]  in_target,
  input  logic [SSD_W-1:0]       thresh,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SSD_W-1:0]       out_score,
  output logic [DIR_W-1:0]       out_dir,
  output logic                   out_corner
);

  localparam int CW = $clog2(WIN);

  typedef enum logic [1:0] {
    ACC = 2'd0,
    MIN = 2'd1,
    OUT = 2'd2
  } state_t;

  state_t state, nstate;

  logic [CW-1:0]    cnt;
  logic [DIR_W-1:0] idx;
  logic [SSD_W-1:0] acc [NDIR];
  logic [SSD_W-1:0] minv;
  logic [DIR_W-1:0] mind;
  logic             rdy;

  logic [2*PIX_W-1:0] sq [NDIR];
  logic               fire_in;
  logic               last_beat;
  logic               last_dir;
  logic [SSD_W-1:0]   cand;
  logic               take;
  logic [SSD_W-1:0]   nminv;
  logic [DIR_W-1:0]   nmind;
  logic               corner_n;

  // |target - center| equals the magnitude of the signed difference,
  // so its square is the exact, untruncated squared difference.
  for (genvar g = 0; g < NDIR; g++) begin : g_sq
    logic [PIX_W-1:0]   t;
    logic [PIX_W-1:0]   ad;
    logic [2*PIX_W-1:0] adw;
    assign t   = in_target[g*PIX_W +: PIX_W];
    assign ad  = (t >= in_center) ? t - in_center
                                  : in_center - t;
    assign adw = {{PIX_W{1'b0}}, ad};
    assign sq[g] = adw * adw;
  end

  assign in_ready  = rdy && (state == ACC);
  assign fire_in   = in_valid && in_ready;
  assign last_beat = fire_in && (cnt == CW'(WIN-1));
  assign last_dir  = (idx == DIR_W'(NDIR-1));

  // Running-min step: first direction always loads, later ones only
  // replace on strictly smaller, so ties keep the lowest index.
  assign cand  = acc[idx];
  assign take  = (idx == '0) || (cand < minv);
  assign nminv = take ? cand : minv;
  assign nmind = take ? idx  : mind;

`ifdef MORAVEC_THRESH_EN
  assign corner_n = (nminv > thresh);
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh;
  assign corner_n      = 1'b0;
`endif

  // Next-state selection; flush overrides everything.
  always_comb begin
    nstate = state;
    unique case (state)
      ACC:     if (last_beat) nstate = MIN;
      MIN:     if (last_dir)  nstate = OUT;
      OUT:     if (out_ready) nstate = ACC;
      default: nstate = ACC;
    endcase
    if (flush) nstate = ACC;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACC;
      rdy        <= 1'b0;
      cnt        <= '0;
      idx        <= '0;
      minv       <= '0;
      mind       <= '0;
      out_valid  <= 1'b0;
      out_score  <= '0;
      out_dir    <= '0;
      out_corner <= 1'b0;
      for (int d = 0; d < NDIR; d++) acc[d] <= '0;
    end else begin
      state <= nstate;
      rdy   <= 1'b1;
      if (flush) begin
        cnt       <= '0;
        idx       <= '0;
        out_valid <= 1'b0;
        for (int d = 0; d < NDIR; d++) acc[d] <= '0;
      end else begin
        unique case (state)
          ACC: begin
            if (fire_in) begin
              cnt <= last_beat ? '0 : cnt + 1'b1;
              for (int d = 0; d < NDIR; d++)
                acc[d] <= acc[d] + SSD_W'(sq[d]);
            end
          end
          MIN: begin
            minv <= nminv;
            mind <= nmind;
            idx  <= last_dir ? '0 : idx + 1'b1;
            if (last_dir) begin
              out_valid  <= 1'b1;
              out_score  <= nminv;
              out_dir    <= nmind;
              out_corner <= corner_n;
            end
          end
          OUT: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              for (int d = 0; d < NDIR; d++) acc[d] <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_moravec_score_unit.sv
// Scoreboard bench for moravec_score_unit: random and directed windows
// checked against a plain-arithmetic SSD/min model.
module tb_moravec_score_unit;

  localparam int PIX_W = 8;
  localparam int NDIR  = 4;
  localparam int WIN   = 9;
  localparam int SSD_W = 2*PIX_W + $clog2(WIN);
  localparam int DIR_W = $clog2(NDIR);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [PIX_W-1:0]      in_center;
  logic [NDIR*PIX_W-1:0] in_target;
  logic [SSD_W-1:0]      thresh;
  logic                  out_valid;
  logic                  out_ready;
  logic [SSD_W-1:0]      out_score;
  logic [DIR_W-1:0]      out_dir;
  logic                  out_corner;

  moravec_score_unit #(
    .PIX_W(PIX_W),
    .NDIR (NDIR),
    .WIN  (WIN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_center (in_center),
    .in_target (in_target),
    .thresh    (thresh),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_score (out_score),
    .out_dir   (out_dir),
    .out_corner(out_corner)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint score;
    int     dir;
    bit     corner;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   thr    = 0;

  function automatic void chk(input string nm,
                              input longint act,
                              input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle a result is presented it must match the head
  // of the scoreboard; the entry retires on the handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        chk("out_valid_unexpected", out_valid, 0);
      end else begin
        chk("out_score", out_score, q[0].score);
        chk("out_dir", out_dir, q[0].dir);
        chk("out_corner", out_corner, q[0].corner);
        chk("in_ready_in_out", in_ready, 0);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic beat(input int c, input logic [NDIR*PIX_W-1:0] t);
    int n = 0;
    in_valid  = 1'b1;
    in_center = PIX_W'(c);
    in_target = t;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // kind: 0 random, 1 small range (ties), 2 fixed pattern,
  // 3 flat 50, other: extremes
  task automatic run_window(input int kind, input bit gaps);
    int c;
    int tv[NDIR];
    int pat[NDIR];
    longint acc[NDIR];
    logic [NDIR*PIX_W-1:0] t;
    exp_t e;
    pat = '{13, 12, 20, 10};
    for (int d = 0; d < NDIR; d++) acc[d] = 0;
    for (int b = 0; b < WIN; b++) begin
      case (kind)
        0: c = $urandom_range(0, 255);
        1: c = $urandom_range(0, 3);
        2: c = 10;
        3: c = 50;
        default: c = 255;
      endcase
      for (int d = 0; d < NDIR; d++) begin
        case (kind)
          0: tv[d] = $urandom_range(0, 255);
          1: tv[d] = $urandom_range(0, 3);
          2: tv[d] = pat[d];
          3: tv[d] = 50;
          default: tv[d] = 0;
        endcase
        t[d*PIX_W +: PIX_W] = PIX_W'(tv[d]);
        acc[d] += longint'((tv[d] - c) * (tv[d] - c));
      end
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      beat(c, t);
    end
    e.score = acc[0];
    e.dir   = 0;
    for (int d = 1; d < NDIR; d++)
      if (acc[d] < e.score) begin
        e.score = acc[d];
        e.dir   = d;
      end
`ifdef MORAVEC_THRESH_EN
    e.corner = (e.score > thr);
`else
    e.corner = 1'b0;
`endif
    q.push_back(e);
  endtask

  task automatic set_thr(input int v);
    thr    = v;
    thresh = SSD_W'(v);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    chk(nm, out_valid, 1);
  endtask

  task automatic drain(input int stall);
    int n = 0;
    if (stall > 0) begin
      out_ready = 1'b0;
      wait_valid("stall_valid_seen");
      repeat (stall) tick();
    end
    out_ready = 1'b1;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_done", q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [NDIR*PIX_W-1:0] rt;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_center = '0;
    in_target = '0;
    out_ready = 1'b1;
    set_thr(0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_score", out_score, 0);
    chk("rst_out_dir", out_dir, 0);
    chk("rst_out_corner", out_corner, 0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", in_ready, 0);
    tick();
    chk("ready_after_edge", in_ready, 1);

    // flat image: all SSDs zero
    set_thr(1);
    run_window(3, 1'b0);
    drain(0);

    // fixed pattern with latency measurement
    set_thr(50);
    run_window(2, 1'b0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency_cycles", lat, NDIR + 1);
    drain(0);

    // extremes, no wrap
    set_thr(1000);
    run_window(4, 1'b0);
    drain(0);

    // backpressure for 6 cycles
    out_ready = 1'b0;
    run_window(0, 1'b0);
    wait_valid("bp_valid_seen");
    for (int i = 0; i < 6; i++) begin
      chk("bp_out_valid_held", out_valid, 1);
      chk("bp_in_ready_low", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_ready_after_hs", in_ready, 1);
    chk("bp_valid_after_hs", out_valid, 0);

    // flush after 4 beats; beat presented with flush is discarded
    for (int b = 0; b < 4; b++) begin
      rt = NDIR*PIX_W'($urandom());
      beat($urandom_range(0, 255), rt);
    end
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_center = 8'd200;
    in_target = {8'd1, 8'd2, 8'd3, 8'd4};
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_ready", in_ready, 1);
    run_window(2, 1'b0);
    drain(0);

    // reset during MIN: no output, next window correct
    set_thr(500);
    run_window(0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    void'(q.pop_back());
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_score", out_score, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("midrst_no_pulse", out_valid, 0);
    run_window(0, 1'b1);
    drain(0);

    // flush together with handshake: result delivered
    out_ready = 1'b0;
    run_window(1, 1'b0);
    wait_valid("fhs_valid_seen");
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    chk("fhs_out_valid", out_valid, 0);
    chk("fhs_in_ready", in_ready, 1);
    chk("fhs_delivered", q.size(), 0);

    // randomized windows
    for (int w = 0; w < 24; w++) begin
      set_thr($urandom_range(0, 150000));
      run_window($urandom_range(0, 1), 1'($urandom()));
      drain($urandom_range(0, 3));
    end

    repeat (5) tick();
    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
